// File: rtl/matrix_uart_printer_if.sv
// ============================================================================
// Module   : matrix_uart_printer_if
// Brief    : Control, BRAM read and UART byte-stream signals of the printer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface matrix_uart_printer_if #(
  parameter int ADDR_WIDTH = 14
);
  logic                  start;
  logic [2:0]            matrix_id;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [31:0]           bram_data;
  logic [7:0]            uart_tx_data;
  logic                  uart_tx_valid;
  logic                  uart_tx_ready;
  logic                  busy;
  logic                  done;
  logic                  error;

  // The printer drives BRAM address, UART bytes and status.
  modport master (
    input  start, matrix_id, bram_data, uart_tx_ready,
    output bram_addr, uart_tx_data, uart_tx_valid, busy, done, error
  );

  modport slave (
    output start, matrix_id, bram_data, uart_tx_ready,
    input  bram_addr, uart_tx_data, uart_tx_valid, busy, done, error
  );
endinterface

`default_nettype wire

// File: rtl/matrix_uart_printer.sv
// ============================================================================
// Module   : matrix_uart_printer
// Brief    : Reads a matrix slot from BRAM and streams it as signed decimal
//            ASCII text over a valid/ready byte interface.
//            Optional macro PRINTER_HEADER_EN prefixes the "<rows> <cols>\n" line.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_uart_printer #(
  parameter int BLOCK_SIZE = 1152,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  matrix_uart_printer_if.master   bus
);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    HDR_RD     = 4'd1,
    HDR_WAIT   = 4'd2,
    ELEM_RD    = 4'd3,
    ELEM_WAIT  = 4'd4,
    CONV       = 4'd5,
    EMIT_SIGN  = 4'd6,
    EMIT_DIGIT = 4'd7,
    EMIT_SEP   = 4'd8,
    EMIT_NL    = 4'd9,
    DONE       = 4'd10,
    EMIT_HDR   = 4'd11
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [2:0]            r_rows;
  logic [2:0]            r_cols;
  logic [2:0]            r_row;
  logic [2:0]            r_col;
  logic                  r_neg;
  logic [31:0]           r_mag;
  logic [3:0]            r_digits [0:9];
  logic [3:0]            r_ndig;
  logic                  r_error;
`ifdef PRINTER_HEADER_EN
  logic [1:0]            r_hdr_idx;
`endif

  logic                  w_valid;
  logic [7:0]            w_data;
  logic                  w_hdr_bad;
  logic [ADDR_WIDTH-1:0] w_base;
  logic [31:0]           w_quot;
  logic [3:0]            w_rem;
  logic [3:0]            w_dig_idx;
  logic                  w_last_col;
  logic                  w_last_row;

  assign w_base     = ADDR_WIDTH'(bus.matrix_id) * ADDR_WIDTH'(BLOCK_SIZE);
  assign w_hdr_bad  = (bus.bram_data[31:24] == 8'd0) || (bus.bram_data[31:24] > 8'd7) ||
                      (bus.bram_data[23:16] == 8'd0) || (bus.bram_data[23:16] > 8'd7);
  assign w_quot     = r_mag / 32'd10;
  assign w_rem      = 4'(r_mag % 32'd10);
  assign w_dig_idx  = r_ndig - 4'd1;
  assign w_last_col = (r_col == r_cols - 3'd1);
  assign w_last_row = (r_row == r_rows - 3'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_valid = 1'b0;
    w_data  = 8'h00;
    case (r_state)
      IDLE:      if (bus.start) w_next = HDR_RD;
      HDR_RD:    w_next = HDR_WAIT;
      HDR_WAIT: begin
        if (w_hdr_bad) w_next = IDLE;
`ifdef PRINTER_HEADER_EN
        else           w_next = EMIT_HDR;
`else
        else           w_next = ELEM_RD;
`endif
      end
      ELEM_RD:   w_next = ELEM_WAIT;
      ELEM_WAIT: w_next = CONV;
      CONV:      if (w_quot == 32'd0) w_next = r_neg ? EMIT_SIGN : EMIT_DIGIT;
      EMIT_SIGN: begin
        w_valid = 1'b1;
        w_data  = 8'h2D;
        if (bus.uart_tx_ready) w_next = EMIT_DIGIT;
      end
      EMIT_DIGIT: begin
        w_valid = 1'b1;
        w_data  = 8'h30 + {4'h0, r_digits[w_dig_idx]};
        if (bus.uart_tx_ready && r_ndig == 4'd1) w_next = w_last_col ? EMIT_NL : EMIT_SEP;
      end
      EMIT_SEP: begin
        w_valid = 1'b1;
        w_data  = 8'h20;
        if (bus.uart_tx_ready) w_next = ELEM_RD;
      end
      EMIT_NL: begin
        w_valid = 1'b1;
        w_data  = 8'h0A;
        if (bus.uart_tx_ready) w_next = w_last_row ? DONE : ELEM_RD;
      end
      DONE:      w_next = IDLE;
`ifdef PRINTER_HEADER_EN
      EMIT_HDR: begin
        w_valid = 1'b1;
        case (r_hdr_idx)
          2'd0:    w_data = 8'h30 + {5'd0, r_rows};
          2'd1:    w_data = 8'h20;
          2'd2:    w_data = 8'h30 + {5'd0, r_cols};
          default: w_data = 8'h0A;
        endcase
        if (bus.uart_tx_ready && r_hdr_idx == 2'd3) w_next = ELEM_RD;
      end
`endif
      default:   w_next = IDLE;
    endcase
  end

  // Datapath: the address register only moves when a read is being set up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_rows  <= 3'd0;
      r_cols  <= 3'd0;
      r_row   <= 3'd0;
      r_col   <= 3'd0;
      r_neg   <= 1'b0;
      r_mag   <= 32'd0;
      r_ndig  <= 4'd0;
      r_error <= 1'b0;
      for (int i = 0; i < 10; i++) r_digits[i] <= 4'd0;
`ifdef PRINTER_HEADER_EN
      r_hdr_idx <= 2'd0;
`endif
    end else begin
      r_error <= 1'b0;
      case (r_state)
        IDLE: if (bus.start) r_addr <= w_base;
        HDR_WAIT: begin
          r_rows  <= bus.bram_data[26:24];
          r_cols  <= bus.bram_data[18:16];
          r_row   <= 3'd0;
          r_col   <= 3'd0;
          r_error <= w_hdr_bad;
          if (!w_hdr_bad) r_addr <= r_addr + ADDR_WIDTH'(3);
`ifdef PRINTER_HEADER_EN
          r_hdr_idx <= 2'd0;
`endif
        end
        ELEM_WAIT: begin
          // Magnitude is unsigned so the most negative value survives negation.
          r_neg  <= bus.bram_data[31];
          r_mag  <= bus.bram_data[31] ? (~bus.bram_data + 32'd1) : bus.bram_data;
          r_ndig <= 4'd0;
        end
        CONV: begin
          r_digits[r_ndig] <= w_rem;
          r_ndig           <= r_ndig + 4'd1;
          r_mag            <= w_quot;
        end
        EMIT_DIGIT: if (bus.uart_tx_ready) r_ndig <= r_ndig - 4'd1;
        EMIT_SEP: if (bus.uart_tx_ready) begin
          r_col  <= r_col + 3'd1;
          r_addr <= r_addr + ADDR_WIDTH'(1);
        end
        EMIT_NL: if (bus.uart_tx_ready && !w_last_row) begin
          r_row  <= r_row + 3'd1;
          r_col  <= 3'd0;
          r_addr <= r_addr + ADDR_WIDTH'(1);
        end
`ifdef PRINTER_HEADER_EN
        EMIT_HDR: if (bus.uart_tx_ready) r_hdr_idx <= r_hdr_idx + 2'd1;
`endif
        default: ;
      endcase
    end
  end

  assign bus.bram_addr     = r_addr;
  assign bus.uart_tx_valid = w_valid;
  assign bus.uart_tx_data  = w_data;
  assign bus.busy          = (r_state != IDLE);
  assign bus.done          = (r_state == DONE);
  assign bus.error         = r_error;

endmodule

`default_nettype wire
